enemy_hit_judge: RTL and testbench
==================================

// Module: enemy_hit_judge
// PURPOSE
//  Parametrised enemy damage/explosion judge for the shooter game datapath. Checks N player
//  bullets against one enemy hitbox each clk, consumes the hitting bullet, decrements health,
//  applies post-hit invulnerability, then runs a timed explosion. Sits between the bullet
//  pool and enemy renderer; one instance per enemy slot.
// PARAMETERS
//  N_BULLETS    4    bullets checked in parallel
//  COORD_W      10   coordinate width
//  HEALTH_W     3    health width
//  MAX_HEALTH   5    health loaded on spawn (clamped to 2^HEALTH_W-1)
//  Y_OFFSET     480  added to ep_y before compare (enemy-to-screen space)
//  HB_XL/HB_XR  10/50  hitbox: b_x-HB_XL <= ex < b_x+HB_XR
//  HB_YU/HB_YD  50/40  hitbox: b_y-HB_YU <= ey < b_y+HB_YD
//  HIT_FRAMES   4    invulnerable frames after a non-fatal hit
//  BOOM_FRAMES  8    frames boom is held high
// PORTS
//  clk          in   1                    system clock
//  rst          in   1                    async reset, active-low
//  frame_tick   in   1                    1-clk strobe per video frame
//  spawn        in   1                    load MAX_HEALTH, enter ALIVE
//  enemy_en     in   1                    enemy present; low aborts to IDLE
//  ep_x, ep_y   in   COORD_W              enemy position
//  b_x, b_y     in   N_BULLETS*COORD_W    packed bullet positions, bullet i at [i*COORD_W +: COORD_W]
//  mb_en        in   N_BULLETS            bullet i live
//  mb_clr       out  N_BULLETS            1-clk pulse: bullet i consumed
//  health       out  HEALTH_W             current health
//  hit_flash    out  1                    high while in HIT
//  boom         out  1                    high while in BOOM
//  dead         out  1                    high in DEAD
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, health=0, mb_clr=0, counters=0; all outputs 0.
//  Arithmetic: ex=ep_x, ey=ep_y+Y_OFFSET, both zero-extended to COORD_W+2 bits and compared
//   signed vs b-HB and b+HB at COORD_W+2 bits; no truncation/wrap (b_x<HB_XL not a false miss).
//  hit_i = mb_en[i] & enemy_en & in-box(i). Winner = lowest index i with hit_i.
//  States:
//   IDLE : spawn -> ALIVE, health<=MAX_HEALTH. No hits judged.
//   ALIVE: any hit_i -> mb_clr[winner]=1 next clk (registered, 1-clk latency), health-=1;
//          health was 1 -> BOOM (cnt=0); else -> HIT (cnt=0). Only winner consumed; other
//          hitting bullets stay live.
//   HIT  : no hits judged, no bullets consumed. cnt++ on frame_tick; cnt==HIT_FRAMES-1 with tick -> ALIVE.
//   BOOM : boom=1. cnt++ on frame_tick; after BOOM_FRAMES ticks -> DEAD.
//   DEAD : dead=1, health=0. spawn -> ALIVE (respawn).
//  enemy_en=0 in ALIVE/HIT -> IDLE next clk, health<=0, no boom. In BOOM, enemy_en ignored (explosion completes).
//  spawn in any state other than IDLE/DEAD ignored. spawn and hit same clk in IDLE: spawn wins, no hit.
//  health never underflows; health==0 only in IDLE/BOOM/DEAD.
//  frame_tick and hit same clk in HIT: tick counts, hit ignored.
//  mb_clr is one-hot or zero; never asserted outside ALIVE->(HIT|BOOM) transition.
// TESTING
//  Reset: hold rst=0, toggle inputs -> all outputs 0, state IDLE; release -> stays IDLE.
//  Spawn, ep=(100,0), bullet0 (100,500) live -> next clk mb_clr=0001, health 5->4, hit_flash=1;
//   4 frame_ticks later hit_flash=0, ALIVE.
//  Bullets 1 and 3 both in box same clk -> mb_clr=0010 only, health-1, bullet 3 not consumed during HIT.
//  Five spaced hits from MAX_HEALTH=5 -> health 0, boom=1 for exactly 8 frame_ticks, then dead=1; spawn -> health 5.
//  Edge: b_x=5, ep_x=0 (b_x-HB_XL negative) -> hit; ep_x=b_x+50 -> miss; ey=b_y+39 hit, +40 miss.
//  enemy_en drops in HIT -> IDLE, boom never asserts; drops in BOOM -> boom runs full 8 ticks.

Source files
------------

// File: rtl/enemy_hit_judge.sv
// Enemy hit/damage/explosion judge: N bullets vs one hitbox per clk, health, invulnerability, timed boom.
// All outputs registered (1 clk after inputs); no backpressure, mb_clr is a one-clk consume strobe.
module enemy_hit_judge #(
    parameter int N_BULLETS   = 4,
    parameter int COORD_W     = 10,
    parameter int HEALTH_W    = 3,
    parameter int MAX_HEALTH  = 5,
    parameter int Y_OFFSET    = 480,
    parameter int HB_XL       = 10,
    parameter int HB_XR       = 50,
    parameter int HB_YU       = 50,
    parameter int HB_YD       = 40,
    parameter int HIT_FRAMES  = 4,
    parameter int BOOM_FRAMES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           spawn,
    input  logic                           enemy_en,
    input  logic [COORD_W-1:0]             ep_x,
    input  logic [COORD_W-1:0]             ep_y,
    input  logic [N_BULLETS*COORD_W-1:0]   b_x,
    input  logic [N_BULLETS*COORD_W-1:0]   b_y,
    input  logic [N_BULLETS-1:0]           mb_en,
    output logic [N_BULLETS-1:0]           mb_clr,
    output logic [HEALTH_W-1:0]            health,
    output logic                           hit_flash,
    output logic                           boom,
    output logic                           dead
);

    // Two guard bits keep b-HB negative values and ep_y+Y_OFFSET from wrapping.
    localparam int CW      = COORD_W + 2;
    localparam int HMAX    = (1 << HEALTH_W) - 1;
    localparam int FR_MAX  = (HIT_FRAMES > BOOM_FRAMES) ? HIT_FRAMES : BOOM_FRAMES;
    localparam int CNT_W   = $clog2(FR_MAX + 1);

    localparam logic [HEALTH_W-1:0] SPAWN_HEALTH =
        HEALTH_W'((MAX_HEALTH > HMAX) ? HMAX : MAX_HEALTH);
    localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] BOOM_LAST = CNT_W'(BOOM_FRAMES - 1);

    localparam logic signed [CW-1:0] Y_OFF = CW'(Y_OFFSET);
    localparam logic signed [CW-1:0] XL    = CW'(HB_XL);
    localparam logic signed [CW-1:0] XR    = CW'(HB_XR);
    localparam logic signed [CW-1:0] YU    = CW'(HB_YU);
    localparam logic signed [CW-1:0] YD    = CW'(HB_YD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIVE,
        S_HIT,
        S_BOOM,
        S_DEAD
    } state_t;

    state_t                state_q, state_d;
    logic [HEALTH_W-1:0]   health_q, health_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_BULLETS-1:0]  mb_clr_q, mb_clr_d;
    logic                  hit_flash_q, hit_flash_d;
    logic                  boom_q, boom_d;
    logic                  dead_q, dead_d;

    logic signed [CW-1:0]  ex;
    logic signed [CW-1:0]  ey;
    logic [N_BULLETS-1:0]  hit;
    logic [N_BULLETS-1:0]  win_oh;
    logic                  win_found;
    logic                  any_hit;

    assign ex = $signed({2'b00, ep_x});
    assign ey = $signed({2'b00, ep_y}) + Y_OFF;

    for (genvar i = 0; i < N_BULLETS; i++) begin : g_box
        logic signed [CW-1:0] bx;
        logic signed [CW-1:0] by;

        assign bx = $signed({2'b00, b_x[i*COORD_W +: COORD_W]});
        assign by = $signed({2'b00, b_y[i*COORD_W +: COORD_W]});
        assign hit[i] = mb_en[i] & enemy_en
                      & (ex >= bx - XL) & (ex < bx + XR)
                      & (ey >= by - YU) & (ey < by + YD);
    end

    // Lowest-index hitting bullet is the only one consumed.
    always_comb begin
        win_oh    = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (hit[i] && !win_found) begin
                win_oh[i] = 1'b1;
                win_found = 1'b1;
            end
        end
    end

    assign any_hit = |hit;

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        cnt_d    = cnt_q;
        mb_clr_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (spawn) begin
                    state_d  = S_ALIVE;
                    health_d = SPAWN_HEALTH;
                    cnt_d    = '0;
                end
            end
            S_ALIVE: begin
                if (!enemy_en) begin
                    state_d  = S_IDLE;
                    health_d = '0;
                    cnt_d    = '0;
                end else if (any_hit) begin
                    mb_clr_d = win_oh;
                    cnt_d    = '0;
                    if (health_q <= HEALTH_W'(1)) begin
                        state_d  = S_BOOM;
                        health_d = '0;
                    end else begin
                        state_d  = S_HIT;
                        health_d = health_q - HEALTH_W'(1);
                    end
                end
            end
            S_HIT: begin
                if (!enemy_en) begin
                    state_d  = S_IDLE;
                    health_d = '0;
                    cnt_d    = '0;
                end else if (frame_tick) begin
                    if (cnt_q == HIT_LAST) begin
                        state_d = S_ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // The explosion always completes, even if the slot is released.
            S_BOOM: begin
                if (frame_tick) begin
                    if (cnt_q == BOOM_LAST) begin
                        state_d = S_DEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DEAD: begin
                health_d = '0;
                if (spawn) begin
                    state_d  = S_ALIVE;
                    health_d = SPAWN_HEALTH;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                health_d = '0;
                cnt_d    = '0;
            end
        endcase

        hit_flash_d = (state_d == S_HIT);
        boom_d      = (state_d == S_BOOM);
        dead_d      = (state_d == S_DEAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            health_q    <= '0;
            cnt_q       <= '0;
            mb_clr_q    <= '0;
            hit_flash_q <= 1'b0;
            boom_q      <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            health_q    <= health_d;
            cnt_q       <= cnt_d;
            mb_clr_q    <= mb_clr_d;
            hit_flash_q <= hit_flash_d;
            boom_q      <= boom_d;
            dead_q      <= dead_d;
        end
    end

    assign mb_clr    = mb_clr_q;
    assign health    = health_q;
    assign hit_flash = hit_flash_q;
    assign boom      = boom_q;
    assign dead      = dead_q;

endmodule

// File: tb/tb_enemy_hit_judge.sv
// Bench for enemy_hit_judge: directed scenarios, per-cycle model comparison plus literal checks.
module tb_enemy_hit_judge;

    localparam int NB = 4;
    localparam int CW = 10;

    localparam int M_IDLE  = 0;
    localparam int M_ALIVE = 1;
    localparam int M_HIT   = 2;
    localparam int M_BOOM  = 3;
    localparam int M_DEAD  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic              spawn = 1'b0;
    logic              enemy_en = 1'b0;
    logic [CW-1:0]     ep_x = '0;
    logic [CW-1:0]     ep_y = '0;
    logic [NB*CW-1:0]  b_x = '0;
    logic [NB*CW-1:0]  b_y = '0;
    logic [NB-1:0]     mb_en = '0;
    logic [NB-1:0]     mb_clr;
    logic [2:0]        health;
    logic              hit_flash;
    logic              boom;
    logic              dead;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    int         m_mode   = M_IDLE;
    int         m_health = 0;
    int         m_ticks  = 0;
    logic [3:0] m_clr    = '0;

    enemy_hit_judge dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .spawn      (spawn),
        .enemy_en   (enemy_en),
        .ep_x       (ep_x),
        .ep_y       (ep_y),
        .b_x        (b_x),
        .b_y        (b_y),
        .mb_en      (mb_en),
        .mb_clr     (mb_clr),
        .health     (health),
        .hit_flash  (hit_flash),
        .boom       (boom),
        .dead       (dead)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Hitbox rule in plain integer screen space.
    function automatic bit in_box(int i);
        int ex, ey, bx, by;
        ex = int'(ep_x);
        ey = int'(ep_y) + 480;
        bx = int'(b_x[i*CW +: CW]);
        by = int'(b_y[i*CW +: CW]);
        return (ex >= bx - 10) && (ex < bx + 50) && (ey >= by - 50) && (ey < by + 40);
    endfunction

    function automatic int first_hit();
        for (int i = 0; i < NB; i++)
            if (mb_en[i] && enemy_en && in_box(i)) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode   <= M_IDLE;
            m_health <= 0;
            m_ticks  <= 0;
            m_clr    <= '0;
        end else begin
            m_clr <= '0;
            case (m_mode)
                M_IDLE: if (spawn) begin
                    m_mode   <= M_ALIVE;
                    m_health <= 5;
                end
                M_ALIVE: if (!enemy_en) begin
                    m_mode   <= M_IDLE;
                    m_health <= 0;
                end else if (first_hit() >= 0) begin
                    m_clr    <= 4'(1 << first_hit());
                    m_health <= m_health - 1;
                    m_mode   <= (m_health == 1) ? M_BOOM : M_HIT;
                    m_ticks  <= 0;
                end
                M_HIT: if (!enemy_en) begin
                    m_mode   <= M_IDLE;
                    m_health <= 0;
                end else if (frame_tick) begin
                    if (m_ticks + 1 == 4) m_mode <= M_ALIVE;
                    m_ticks <= m_ticks + 1;
                end
                M_BOOM: if (frame_tick) begin
                    if (m_ticks + 1 == 8) m_mode <= M_DEAD;
                    m_ticks <= m_ticks + 1;
                end
                M_DEAD: if (spawn) begin
                    m_mode   <= M_ALIVE;
                    m_health <= 5;
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_mb_clr", 32'(mb_clr), 32'(m_clr));
            chk("cyc_health", 32'(health), 32'(m_health));
            chk("cyc_hit_flash", 32'(hit_flash), 32'(m_mode == M_HIT));
            chk("cyc_boom", 32'(boom), 32'(m_mode == M_BOOM));
            chk("cyc_dead", 32'(dead), 32'(m_mode == M_DEAD));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_b(int i, int x, int y);
        b_x[i*CW +: CW] = CW'(x);
        b_y[i*CW +: CW] = CW'(y);
    endtask

    task automatic hit_once(string nm, logic [3:0] mask, logic [3:0] exp_clr, int exp_h, bit exp_flash);
        mb_en = mask;
        cyc(1);
        chk({nm, "_clr"}, 32'(mb_clr), 32'(exp_clr));
        chk({nm, "_health"}, 32'(health), 32'(exp_h));
        chk({nm, "_flash"}, 32'(hit_flash), 32'(exp_flash));
        mb_en = '0;
        cyc(1);
    endtask

    initial begin
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // Inputs toggling under reset must not move anything.
        ep_x = 10'd100; ep_y = 10'd0;
        set_b(0, 100, 500);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            spawn = ~spawn; enemy_en = 1'b1; mb_en = 4'b1111; frame_tick = ~frame_tick;
        end
        cyc(1);
        chk("rst_health", 32'(health), 32'd0);
        chk("rst_clr", 32'(mb_clr), 32'd0);
        chk("rst_flags", 32'({hit_flash, boom, dead}), 32'd0);
        spawn = 1'b0; mb_en = '0; frame_tick = 1'b0;
        rst = 1'b1;
        cyc(2);
        chk("idle_after_rst", 32'({health, hit_flash, boom, dead}), 32'd0);

        // First hit and invulnerability window.
        spawn = 1'b1;
        cyc(1);
        spawn = 1'b0;
        chk("spawn_health", 32'(health), 32'd5);
        hit_once("hit1", 4'b0001, 4'b0001, 4, 1'b1);
        ticks(3);
        chk("hit1_flash_3t", 32'(hit_flash), 32'd1);
        ticks(1);
        chk("hit1_flash_4t", 32'(hit_flash), 32'd0);

        // Two simultaneous hitters: only the lower index is consumed.
        set_b(1, 100, 500);
        set_b(3, 110, 520);
        mb_en = 4'b1010;
        cyc(1);
        chk("dual_clr", 32'(mb_clr), 32'b0010);
        chk("dual_health", 32'(health), 32'd3);
        mb_en = 4'b1000;
        ticks(3);
        chk("dual_b3_kept", 32'(mb_clr), 32'd0);
        chk("dual_b3_health", 32'(health), 32'd3);
        mb_en = '0;
        ticks(1);
        chk("dual_back_alive", 32'(hit_flash), 32'd0);

        // Drain to zero and explode.
        hit_once("hit3", 4'b0001, 4'b0001, 2, 1'b1);
        ticks(4);
        hit_once("hit4", 4'b0001, 4'b0001, 1, 1'b1);
        ticks(4);
        hit_once("hit5", 4'b0001, 4'b0001, 0, 1'b0);
        chk("boom_on", 32'(boom), 32'd1);
        ticks(7);
        chk("boom_7t", 32'({boom, dead}), 32'b10);
        ticks(1);
        chk("dead_8t", 32'({boom, dead}), 32'b01);
        spawn = 1'b1;
        cyc(1);
        spawn = 1'b0;
        chk("respawn_health", 32'(health), 32'd5);

        // Left edge with negative b_x-HB_XL, and spawn ignored in HIT.
        ep_x = 10'd0; ep_y = 10'd0;
        set_b(0, 5, 500);
        hit_once("edge_xl", 4'b0001, 4'b0001, 4, 1'b1);
        spawn = 1'b1;
        cyc(1);
        spawn = 1'b0;
        chk("spawn_in_hit", 32'(health), 32'd4);
        ticks(4);

        set_b(0, 100, 500);
        ep_x = 10'd150;
        mb_en = 4'b0001;
        cyc(1);
        chk("edge_xr_miss", 32'({mb_clr, health}), 32'({4'b0000, 3'd4}));
        mb_en = '0;
        cyc(1);
        ep_x = 10'd149;
        hit_once("edge_xr_hit", 4'b0001, 4'b0001, 3, 1'b1);
        ticks(4);

        ep_x = 10'd100;
        set_b(0, 100, 441);
        hit_once("edge_yd_hit", 4'b0001, 4'b0001, 2, 1'b1);
        ticks(4);
        set_b(0, 100, 440);
        mb_en = 4'b0001;
        cyc(1);
        chk("edge_yd_miss", 32'({mb_clr, health}), 32'({4'b0000, 3'd2}));
        mb_en = '0;
        cyc(1);

        // Slot released during HIT: straight to IDLE, no explosion.
        set_b(0, 100, 500);
        hit_once("pre_abort", 4'b0001, 4'b0001, 1, 1'b1);
        enemy_en = 1'b0;
        cyc(1);
        chk("abort_state", 32'({health, hit_flash, boom, dead}), 32'd0);
        cyc(2);
        chk("abort_no_boom", 32'(boom), 32'd0);
        enemy_en = 1'b1;

        // Spawn and a live in-box bullet together in IDLE: spawn only.
        spawn = 1'b1;
        mb_en = 4'b0001;
        cyc(1);
        spawn = 1'b0;
        mb_en = '0;
        chk("spawn_wins_h", 32'(health), 32'd5);
        chk("spawn_wins_clr", 32'(mb_clr), 32'd0);
        cyc(1);

        // Slot released during BOOM: explosion still runs its full length.
        for (int k = 0; k < 5; k++) begin
            hit_once("chain", 4'b0001, 4'b0001, 4 - k, k < 4);
            if (k < 4) ticks(4);
        end
        chk("chain_boom", 32'(boom), 32'd1);
        enemy_en = 1'b0;
        ticks(7);
        chk("boom_en_low_7t", 32'({boom, dead}), 32'b10);
        ticks(1);
        chk("boom_en_low_8t", 32'({boom, dead}), 32'b01);
        enemy_en = 1'b1;
        cyc(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
